init_loader: RTL and testbench

//  Upstream init stage for top_with_data_path. Takes a 32-bit valid/ready word stream from the host,

---
 rtl/acc_loader_pkg.sv | 53 +++++
 rtl/init_loader.sv | 184 ++++++++++++++++++
 tb/tb_init_loader.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_loader_pkg.sv
// ----------------------------------------------------------------------------
// acc_loader_pkg
//   Shared definitions for init_loader: header target codes, header field
//   positions and widths, default geometry, FSM state encoding and a header
//   decode helper.
//
//   Header word layout:
//     [31:28] lane mask   [27:26] target   [25:14] base addr   [13:0] count
// ----------------------------------------------------------------------------
package acc_loader_pkg;

    localparam int LANES_DEF  = 4;
    localparam int ADDR_W_DEF = 12;
    localparam int CNT_W_DEF  = 14;

    localparam int HDR_MASK_LSB = 28;
    localparam int HDR_MASK_W   = 4;
    localparam int HDR_TGT_LSB  = 26;
    localparam int HDR_TGT_W    = 2;
    localparam int HDR_ADDR_LSB = 14;
    localparam int HDR_ADDR_W   = 12;
    localparam int HDR_CNT_LSB  = 0;
    localparam int HDR_CNT_W    = 14;

    typedef enum logic [HDR_TGT_W-1:0] {
        TGT_INEX  = 2'b00,
        TGT_STATE = 2'b01,
        TGT_START = 2'b10,
        TGT_STOP  = 2'b11
    } tgt_e;

    typedef struct packed {
        logic [HDR_MASK_W-1:0] mask;
        tgt_e                  tgt;
        logic [HDR_ADDR_W-1:0] base;
        logic [HDR_CNT_W-1:0]  count;
    } hdr_t;

    typedef enum logic {
        HDR = 1'b0,
        PAY = 1'b1
    } state_e;

    function automatic hdr_t decode_hdr(input logic [31:0] word);
        hdr_t h;
        h.mask  = word[HDR_MASK_LSB +: HDR_MASK_W];
        h.tgt   = tgt_e'(word[HDR_TGT_LSB +: HDR_TGT_W]);
        h.base  = word[HDR_ADDR_LSB +: HDR_ADDR_W];
        h.count = word[HDR_CNT_LSB +: HDR_CNT_W];
        return h;
    endfunction

endpackage

// File: rtl/init_loader.sv
// ----------------------------------------------------------------------------
// init_loader
//   Consumes a host valid/ready word stream, decodes packet headers and turns
//   payload words into registered write pulses for the per-lane InexRecur and
//   state regfiles, and drives the is_start run level.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   s_valid/s_ready   stream handshake (ready whenever not in reset)
//   s_data, s_last    stream word and end-of-packet marker
//   inex_we/addr/data per-lane write enable + shared InexRecur addr/data
//   state_we/addr/data per-lane write enable + shared state addr/data
//   is_start          run level to all lanes
//   busy              a payload is in progress
//   err               sticky protocol error
// ----------------------------------------------------------------------------
module init_loader
    import acc_loader_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_data,
    input  logic              s_last,
    output logic [LANES-1:0]  inex_we,
    output logic [ADDR_W-1:0] inex_addr,
    output logic [31:0]       inex_data,
    output logic [LANES-1:0]  state_we,
    output logic [ADDR_W-1:0] state_addr,
    output logic [17:0]       state_data,
    output logic              is_start,
    output logic              busy,
    output logic              err
);

    state_e             state_q, state_d;
    logic [LANES-1:0]   mask_q, mask_d;
    logic               to_inex_q, to_inex_d;
    // Packet accepted but its payload must be swallowed without writes
    // (empty lane mask, or a write packet arriving while running).
    logic               drop_q, drop_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [LANES-1:0]   inex_we_d, state_we_d;
    logic [ADDR_W-1:0]  inex_addr_d, state_addr_d;
    logic [31:0]        inex_data_d;
    logic [17:0]        state_data_d;
    logic               is_start_d, err_d;

    logic               xfer;
    hdr_t               hdr;

    // No downstream stall: ready is only withheld during reset.
    assign s_ready = ~rst;
    assign xfer    = s_valid & s_ready;
    assign hdr     = decode_hdr(s_data);
    assign busy    = (state_q == PAY);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch
        // can leave one unassigned and infer a latch.
        state_d      = state_q;
        mask_d       = mask_q;
        to_inex_d    = to_inex_q;
        drop_d       = drop_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        inex_we_d    = '0;
        state_we_d   = '0;
        inex_addr_d  = inex_addr;
        inex_data_d  = inex_data;
        state_addr_d = state_addr;
        state_data_d = state_data;
        is_start_d   = is_start;
        err_d        = err;

        case (state_q)
            HDR: begin
                if (xfer) begin
                    case (hdr.tgt)
                        TGT_INEX, TGT_STATE: begin
                            if (hdr.count == '0) begin
                                // Empty write packet: header must be the last word.
                                if (!s_last) err_d = 1'b1;
                            end else if (s_last) begin
                                // Packet claims payload but ends at its header.
                                err_d = 1'b1;
                            end else begin
                                state_d   = PAY;
                                mask_d    = LANES'(hdr.mask);
                                to_inex_d = (hdr.tgt == TGT_INEX);
                                addr_d    = ADDR_W'(hdr.base);
                                cnt_d     = CNT_W'(hdr.count);
                                drop_d    = (hdr.mask == '0) || is_start;
                                if ((hdr.mask == '0) || is_start) err_d = 1'b1;
                            end
                        end
                        TGT_START: begin
                            is_start_d = 1'b1;
                            if (!s_last) err_d = 1'b1;
                        end
                        TGT_STOP: begin
                            is_start_d = 1'b0;
                            if (!s_last) err_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            PAY: begin
                if (xfer) begin
                    if (!drop_q) begin
                        if (to_inex_q) begin
                            inex_we_d   = mask_q;
                            inex_addr_d = addr_q;
                            inex_data_d = s_data;
                        end else begin
                            state_we_d   = mask_q;
                            state_addr_d = addr_q;
                            state_data_d = s_data[17:0];
                        end
                    end
                    // Address wraps naturally at 2^ADDR_W.
                    addr_d = addr_q + 1'b1;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = HDR;
                        if (!s_last) err_d = 1'b1;
                    end else if (s_last) begin
                        // Early end: this word is written, rest of packet abandoned.
                        state_d = HDR;
                        err_d   = 1'b1;
                    end
                end
            end

            default: state_d = HDR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= HDR;
            mask_q     <= '0;
            to_inex_q  <= 1'b0;
            drop_q     <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            inex_we    <= '0;
            inex_addr  <= '0;
            inex_data  <= '0;
            state_we   <= '0;
            state_addr <= '0;
            state_data <= '0;
            is_start   <= 1'b0;
            err        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational block.
            state_q    <= state_d;
            mask_q     <= mask_d;
            to_inex_q  <= to_inex_d;
            drop_q     <= drop_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            inex_we    <= inex_we_d;
            inex_addr  <= inex_addr_d;
            inex_data  <= inex_data_d;
            state_we   <= state_we_d;
            state_addr <= state_addr_d;
            state_data <= state_data_d;
            is_start   <= is_start_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_init_loader.sv
// ----------------------------------------------------------------------------
// tb_init_loader
//   Directed packets into init_loader. A packet-level model (remaining word
//   count, base + index addressing modulo 4096) predicts every output; a
//   compare process checks all outputs each falling edge, and literal checks
//   pin the model at key points of each scenario.
// ----------------------------------------------------------------------------
module tb_init_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic [3:0]  inex_we;
    logic [11:0] inex_addr;
    logic [31:0] inex_data;
    logic [3:0]  state_we;
    logic [11:0] state_addr;
    logic [17:0] state_data;
    logic        is_start;
    logic        busy;
    logic        err;

    int checks   = 0;
    int failures = 0;

    init_loader dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .inex_we    (inex_we),
        .inex_addr  (inex_addr),
        .inex_data  (inex_data),
        .state_we   (state_we),
        .state_addr (state_addr),
        .state_data (state_data),
        .is_start   (is_start),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- packet-level model ----------------
    logic [3:0]  e_inex_we    = '0;
    logic [11:0] e_inex_addr  = '0;
    logic [31:0] e_inex_data  = '0;
    logic [3:0]  e_state_we   = '0;
    logic [11:0] e_state_addr = '0;
    logic [17:0] e_state_data = '0;
    logic        e_is_start   = 1'b0;
    logic        e_err        = 1'b0;
    int          m_left       = 0;   // payload words still owed by current packet

    initial begin : model
        int          m_idx;
        int          m_base;
        logic [3:0]  m_mask;
        bit          m_inex;
        bit          m_drop;
        int          tgt;
        int          cnt;
        int          a;
        m_idx = 0; m_base = 0; m_mask = '0; m_inex = 0; m_drop = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                e_inex_we = '0; e_inex_addr = '0; e_inex_data = '0;
                e_state_we = '0; e_state_addr = '0; e_state_data = '0;
                e_is_start = 1'b0; e_err = 1'b0; m_left = 0;
            end else begin
                e_inex_we  = '0;
                e_state_we = '0;
                if (s_valid) begin
                    if (m_left == 0) begin
                        tgt = int'(s_data[27:26]);
                        cnt = int'(s_data[13:0]);
                        if (tgt <= 1) begin
                            if (cnt == 0) begin
                                if (!s_last) e_err = 1'b1;
                            end else if (s_last) begin
                                e_err = 1'b1;
                            end else begin
                                m_left = cnt;
                                m_idx  = 0;
                                m_base = int'(s_data[25:14]);
                                m_mask = s_data[31:28];
                                m_inex = (tgt == 0);
                                m_drop = (m_mask == 4'h0) || e_is_start;
                                if (m_drop) e_err = 1'b1;
                            end
                        end else begin
                            e_is_start = (tgt == 2);
                            if (!s_last) e_err = 1'b1;
                        end
                    end else begin
                        a = (m_base + m_idx) % 4096;
                        if (!m_drop) begin
                            if (m_inex) begin
                                e_inex_we = m_mask; e_inex_addr = 12'(a); e_inex_data = s_data;
                            end else begin
                                e_state_we = m_mask; e_state_addr = 12'(a); e_state_data = s_data[17:0];
                            end
                        end
                        m_idx++;
                        m_left--;
                        if (m_left == 0 && !s_last) e_err = 1'b1;
                        if (m_left > 0 && s_last) begin
                            e_err  = 1'b1;
                            m_left = 0;
                        end
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin : compare
        forever begin
            @(negedge clk);
            check("s_ready",    {31'd0, s_ready}, {31'd0, ~rst});
            check("inex_we",    {28'd0, inex_we},  {28'd0, e_inex_we});
            check("inex_addr",  {20'd0, inex_addr}, {20'd0, e_inex_addr});
            check("inex_data",  inex_data, e_inex_data);
            check("state_we",   {28'd0, state_we}, {28'd0, e_state_we});
            check("state_addr", {20'd0, state_addr}, {20'd0, e_state_addr});
            check("state_data", {14'd0, state_data}, {14'd0, e_state_data});
            check("is_start",   {31'd0, is_start}, {31'd0, e_is_start});
            check("busy",       {31'd0, busy}, {31'd0, (m_left > 0)});
            check("err",        {31'd0, err}, {31'd0, e_err});
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [31:0] w, input logic l);
        s_valid = 1'b1;
        s_data  = w;
        s_last  = l;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin : driver
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("rst_busy",    {31'd0, busy}, 32'd0);
        check("rst_inex_we", {28'd0, inex_we}, 32'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // 1) INEX, mask F, base 1, count 2
        send(32'hF000_4002, 1'b0);
        check("t1_busy_hdr", {31'd0, busy}, 32'd1);
        send(32'h0201_0006, 1'b0);
        check("t1_we1",   {28'd0, inex_we}, 32'hF);
        check("t1_addr1", {20'd0, inex_addr}, 32'd1);
        check("t1_data1", inex_data, 32'h0201_0006);
        send(32'hAABB_CCDD, 1'b1);
        check("t1_addr2", {20'd0, inex_addr}, 32'd2);
        check("t1_data2", inex_data, 32'hAABB_CCDD);
        check("t1_swe",   {28'd0, state_we}, 32'd0);
        check("t1_busy",  {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // 2) STATE, mask 0101, base 0, count 1
        send(32'h5400_0001, 1'b0);
        send(32'h0003_FFFF, 1'b1);
        check("t2_swe",   {28'd0, state_we}, 32'h5);
        check("t2_saddr", {20'd0, state_addr}, 32'd0);
        check("t2_sdata", {14'd0, state_data}, 32'h3FFFF);
        check("t2_iwe",   {28'd0, inex_we}, 32'd0);

        // 3) address wrap: INEX mask 3, base 0xFFF, count 2
        send(32'h33FF_C002, 1'b0);
        send(32'h1111_1111, 1'b0);
        check("t3_addr_fff", {20'd0, inex_addr}, 32'hFFF);
        send(32'h2222_2222, 1'b1);
        check("t3_addr_000", {20'd0, inex_addr}, 32'h000);
        check("t3_we",       {28'd0, inex_we}, 32'h3);
        check("t3_err",      {31'd0, err}, 32'd0);

        // 4) START, blocked write, STOP
        send(32'h0800_0000, 1'b1);
        check("t4_start", {31'd0, is_start}, 32'd1);
        send(32'hF000_0001, 1'b0);
        send(32'h0000_1234, 1'b1);
        check("t4_no_we", {28'd0, inex_we}, 32'd0);
        check("t4_data_held", inex_data, 32'h2222_2222);
        check("t4_err",   {31'd0, err}, 32'd1);
        send(32'h0C00_0000, 1'b1);
        check("t4_stop",  {31'd0, is_start}, 32'd0);

        // 6) reset in the middle of a payload
        send(32'h1004_0004, 1'b0);
        send(32'h5555_0001, 1'b0);
        check("t6_we_before", {28'd0, inex_we}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("t6_we_rst",   {28'd0, inex_we}, 32'd0);
        check("t6_busy_rst", {31'd0, busy}, 32'd0);
        check("t6_start_rst", {31'd0, is_start}, 32'd0);
        check("t6_err_rst",  {31'd0, err}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        send(32'h2004_0001, 1'b0);
        send(32'hCAFE_F00D, 1'b1);
        check("t6_we_after",   {28'd0, inex_we}, 32'h2);
        check("t6_addr_after", {20'd0, inex_addr}, 32'h010);
        check("t6_data_after", inex_data, 32'hCAFE_F00D);
        check("t6_err_after",  {31'd0, err}, 32'd0);

        // 5) early s_last: STATE mask C, base 5, count 3, ends on 2nd payload
        send(32'hC401_4003, 1'b0);
        send(32'h0000_0AAA, 1'b0);
        send(32'h0000_0BBB, 1'b1);
        check("t5_swe",   {28'd0, state_we}, 32'hC);
        check("t5_saddr", {20'd0, state_addr}, 32'd6);
        check("t5_busy",  {31'd0, busy}, 32'd0);
        check("t5_err",   {31'd0, err}, 32'd1);
        send(32'h8400_0001, 1'b0);
        send(32'h0001_2345, 1'b1);
        check("t5_next_we",   {28'd0, state_we}, 32'h8);
        check("t5_next_addr", {20'd0, state_addr}, 32'd0);
        check("t5_next_data", {14'd0, state_data}, 32'h12345);

        // empty lane mask: payload swallowed, next packet still decoded as header
        send(32'h0000_0002, 1'b0);
        send(32'h7777_7777, 1'b0);
        send(32'h8888_8888, 1'b1);
        check("m0_no_we", {28'd0, inex_we}, 32'd0);
        check("m0_busy",  {31'd0, busy}, 32'd0);
        send(32'h4000_0001, 1'b0);
        send(32'h9999_0000, 1'b1);
        check("m0_next_we",   {28'd0, inex_we}, 32'h4);
        check("m0_next_data", inex_data, 32'h9999_0000);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
